alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the core's execute stage (port 0) and a debug/test requester (port 1).
- Uses round-robin arbitration and a valid/ready handshake on each request and response port.
- Registers the granted operands, drives the ALU ports, captures result/zero, and returns them to the granted requester only.
- Sits between the requesters and the ALU instance; the ALU's outputs connect back into this block.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op1  input  XLEN  requester 0 operand 1.
- req0_op2  input  XLEN  requester 0 operand 2.
- req0_ctrl  input  4  requester 0 ALU control code.
- rsp0_valid  output  1  result available for requester 0.
- rsp0_ready  input  1  requester 0 consumes the result.
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl  same as port 0, for requester 1.
- rsp1_valid, rsp1_ready  same as port 0, for requester 1.
- rsp_result  output  XLEN  registered ALU result, shared by both response ports.
- rsp_zero  output  1  registered ALU zero flag.
- alu_op1  output  XLEN  to ALU op1.
- alu_op2  output  XLEN  to ALU op2.
- alu_ctrl  output  4  to ALU_control.
- alu_result  input  XLEN  from ALU.
- alu_zero  input  1  from ALU.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  completed operations; saturating.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - On reset: state=IDLE, rr_ptr=0 (port 0 preferred), grant=0.
  - On reset, all ready/valid outputs=0, rsp_result=0, rsp_zero=0, op_count=0.
  - On reset, operand/ctrl registers are cleared, so alu_op1=alu_op2=0 and alu_ctrl=4'b0000.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner selection:
    - Both valid: winner = rr_ptr.
    - Exactly one valid: winner = that port.
    - Neither valid: stay in IDLE.
  - reqN_ready is asserted combinationally for the winner only.
  - The winner's op1/op2/ctrl are latched into internal registers at the clock edge, and grant=winner.
  - Next state is EXEC.
- EXEC:
  - alu_op1/alu_op2/alu_ctrl always reflect the latched registers.
  - At the end of the cycle, alu_result→rsp_result and alu_zero→rsp_zero.
  - Next state is RESP.
- RESP:
  - rspN_valid=1 for N=grant only; the other port's rsp_valid stays 0.
  - rsp_result and rsp_zero are held stable until the handshake completes.
  - On rsp_ready of the granted port:
    - rr_ptr = ~grant.
    - op_count increments, saturating at all-ones.
    - Next state is IDLE.
  - Without rsp_ready, the block stays in RESP indefinitely. No new request is accepted and both req_ready stay 0.
- Latency and throughput:
  - Request accepted at cycle N → rsp_valid high from cycle N+2.
  - Minimum initiation interval is 3 cycles (rsp_ready tied high).
- Fairness:
  - With both ports continuously valid, grants strictly alternate 0,1,0,1…
  - A lone requester is granted back-to-back.
- Request stability: req operands are sampled only in the accept cycle; changes at other times are ignored.
- Control codes: the block passes ctrl through unmodified.
  - Defined codes: ADD=0010, SUB=0110, AND=0000, OR=0001, SLL=1000, GTE=0111, LTE=1001.
- Reset mid-operation: the in-flight operation is discarded with no response issued, and the block returns to IDLE with rr_ptr=0.
- Zero flag: rsp_zero is the captured alu_zero; it is not recomputed in this block.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_CHK_EN.
- Enabled:
  - Adds output rsp_err (1 bit, reset 0).
  - In EXEC, if the latched ctrl is not one of the 7 defined codes:
    - rsp_result=0, rsp_zero=1, rsp_err=1.
    - The ALU output is ignored for that operation.
  - rsp_err=0 for defined codes.
  - rsp_err is valid alongside rsp_valid.
- Disabled: no rsp_err port; undefined codes pass through and the ALU's default behaviour is returned.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Response: all outputs 0 immediately (alu_ctrl=0000, op_count=0).
- Single request, port 0:
  - Stimulus: op1=7, op2=5, ctrl=0110 (SUB), rsp0_ready=1.
  - Response: req0_ready in the accept cycle; rsp0_valid 2 cycles later with rsp_result=2, rsp_zero=0; rsp1_valid=0; op_count=1.
- Simultaneous requests, sustained for 4 operations:
  - Stimulus: port 0 ADD 3+3; port 1 AND 0xF0&0x0F; both held valid.
  - Response: grant order 0,1,0,1; port 1 results rsp_result=0, rsp_zero=1; port 0 results 6.
- Response backpressure:
  - Stimulus: port 1 SLL op1=1, op2=31; hold rsp1_ready=0 for 5 cycles.
  - Response: rsp1_valid held; rsp_result=0x80000000 stable; req0_ready stays 0 although req0_valid=1.
- Reset mid-EXEC:
  - Stimulus: pulse rst_n low during EXEC.
  - Response: no rsp_valid is ever issued for that operation; state returns to IDLE; the next request completes normally.
- Illegal-code check (ALU_ARB_ILLEGAL_CHK_EN):
  - Stimulus: ctrl=1111.
  - Response: rsp_err=1, rsp_result=0, rsp_zero=1.
  - Follow-up: a subsequent ctrl=0010 gives rsp_err=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Latency: request accepted in cycle N gives rsp_valid from cycle N+2; initiation interval 3 cycles.
// Backpressure: holds the response in RESP until the granted rsp_ready; no request accepted meanwhile.
// Optional feature macro ALU_ARB_ILLEGAL_CHK_EN adds rsp_err and squashes undefined ctrl codes.
module alu_share_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_op1,
  input  logic [XLEN-1:0]  req0_op2,
  input  logic [3:0]       req0_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_op1,
  input  logic [XLEN-1:0]  req1_op2,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  output logic             rsp_err,
`endif
  output logic [XLEN-1:0]  alu_op1,
  output logic [XLEN-1:0]  alu_op2,
  output logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_q, grant_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic              err_q, err_d;
  logic              ctrl_legal;

  // Decode whether the latched ctrl is one of the seven defined ALU codes.
  always_comb begin
    case (ctrl_q)
      4'b0010, 4'b0110, 4'b0000, 4'b0001,
      4'b1000, 4'b0111, 4'b1001: ctrl_legal = 1'b1;
      default:                   ctrl_legal = 1'b0;
    endcase
  end

  assign rsp_err = err_q;
`endif

  // Arbitration, operand capture, result capture and response handshake.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cnt_d      = cnt_q;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    err_d      = err_q;
`endif
    win        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention goes to the round-robin pointer; a lone requester always wins.
          win        = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
          req0_ready = ~win;
          req1_ready = win;
          grant_d    = win;
          op1_d      = win ? req1_op1  : req0_op1;
          op2_d      = win ? req1_op2  : req0_op2;
          ctrl_d     = win ? req1_ctrl : req0_ctrl;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
        err_d    = 1'b0;
        if (!ctrl_legal) begin
          result_d = '0;
          zero_d   = 1'b1;
          err_d    = 1'b1;
        end
`endif
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          rr_ptr_d = ~grant_q;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      ctrl_q   <= 4'b0000;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != S_IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: vector table, hand sequences and randomized traffic
// against a transaction-level reference (winner choice, ALU result, saturating count).
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] rsp_result, alu_op1, alu_op2, alu_result;
  logic        rsp_zero, alu_zero, busy;
  logic [3:0]  alu_ctrl;
  logic [15:0] op_count;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic        rsp_err;
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          rr_m;
  logic [15:0] cnt_m;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    .rsp_err(rsp_err),
`endif
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // ALU behaviour; undefined codes return op1^op2 so pass-through is observable.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1000: return a << b[4:0];
      4'b0111: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    return c inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1000, 4'b0111, 4'b1001};
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_op1, alu_op2, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op1 = 0; req0_op2 = 0; req0_ctrl = 0;
    req1_op1 = 0; req1_op2 = 0; req1_ctrl = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
    chk({tag, "_result"}, rsp_result, 0);
    chk({tag, "_zero"}, rsp_zero, 0);
    chk({tag, "_alu_ops"}, {alu_op1, alu_op2}, 0);
    chk({tag, "_alu_ctrl"}, alu_ctrl, 4'b0000);
    chk({tag, "_op_count"}, op_count, 0);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    chk({tag, "_err"}, rsp_err, 0);
`endif
  endtask

  // One full transaction starting and ending at a falling edge with the DUT idle.
  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                     input logic [31:0] er, input bit ez, input bit ee,
                     input int stall, input bit poke, input string tag);
    bit w;
    w = (v0 && v1) ? rr_m : v1;
    req0_valid = v0; req0_op1 = a0; req0_op2 = b0; req0_ctrl = c0;
    req1_valid = v1; req1_op1 = a1; req1_op2 = b1; req1_ctrl = c1;
    #1;
    chk({tag, "_req_ready"}, {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    req0_op1 = $urandom; req0_op2 = $urandom; req0_ctrl = 4'($urandom);
    req1_op1 = $urandom; req1_op2 = $urandom; req1_ctrl = 4'($urandom);
    @(negedge clk);
    chk({tag, "_exec_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_alu_ops"}, {alu_op1, alu_op2, alu_ctrl},
        w ? {a1, b1, c1} : {a0, b0, c0});
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      if (poke) begin
        if (w) req0_valid = 1; else req1_valid = 1;
        #1;
      end
      chk({tag, "_resp_req_ready"}, {req1_ready, req0_ready}, 0);
      chk({tag, "_rsp_valid"}, {rsp1_valid, rsp0_valid}, w ? 2'b10 : 2'b01);
      chk({tag, "_result"}, rsp_result, er);
      chk({tag, "_zero"}, rsp_zero, ez);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      chk({tag, "_err"}, rsp_err, ee);
`endif
    end
    req0_valid = 0; req1_valid = 0;
    if (w) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge clk); #1;
    rsp0_ready = 0; rsp1_ready = 0;
    rr_m = ~w;
    if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 1'b1;
    @(negedge clk);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_rsp_valid"}, {rsp1_valid, rsp0_valid}, 0);
    chk({tag, "_op_count"}, op_count, cnt_m);
  endtask

  typedef struct {
    bit          port;
    logic [31:0] op1, op2;
    logic [3:0]  ctrl;
    logic [31:0] exp_res;
    bit          exp_zero;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 32'd7,    32'd5,  4'b0110, 32'd2,          0};
    vt[1] = '{1, 32'hF0,   32'h0F, 4'b0000, 32'd0,          1};
    vt[2] = '{0, 32'd3,    32'd3,  4'b0010, 32'd6,          0};
    vt[3] = '{1, 32'd1,    32'd31, 4'b1000, 32'h8000_0000,  0};
    vt[4] = '{0, 32'hA,    32'h5,  4'b0001, 32'hF,          0};
    vt[5] = '{1, 32'd5,    32'd3,  4'b0111, 32'd1,          0};
    vt[6] = '{0, 32'd5,    32'd3,  4'b1001, 32'd0,          1};
    vt[7] = '{1, 32'd9,    32'd9,  4'b0110, 32'd0,          1};

    // Power-on reset.
    idle_inputs();
    rst_n = 0;
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1;
    rr_m = 0; cnt_m = 0;
    @(negedge clk);
    chk_reset_outputs("por_release");

    // Vector table, one requester at a time.
    for (int i = 0; i < 8; i++) begin
      txn(!vt[i].port, vt[i].port,
          vt[i].op1, vt[i].op2, vt[i].ctrl, vt[i].op1, vt[i].op2, vt[i].ctrl,
          vt[i].exp_res, vt[i].exp_zero, 0, i % 3, 0, $sformatf("vec%0d", i));
    end

    // Response backpressure: port 1 SLL held 5 cycles while port 0 pokes.
    txn(0, 1, 0, 0, 0, 32'd1, 32'd31, 4'b1000, 32'h8000_0000, 0, 0, 5, 1, "bp");

    // Asynchronous reset mid-cycle while a response is pending.
    req1_valid = 1; req1_op1 = 32'h1234; req1_op2 = 32'h1; req1_ctrl = 4'b0010;
    @(posedge clk); #1; req1_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("pend_rsp1_valid", rsp1_valid, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1;
    rr_m = 0; cnt_m = 0;

    // Both requesters held valid: grants must alternate 0,1,0,1.
    req0_valid = 1; req0_op1 = 3; req0_op2 = 3; req0_ctrl = 4'b0010;
    req1_valid = 1; req1_op1 = 32'hF0; req1_op2 = 32'h0F; req1_ctrl = 4'b0000;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = -1;
      for (int t = 0; t < 6 && g < 0; t++) begin
        if (req0_ready) g = 0;
        else if (req1_ready) g = 1;
        else @(negedge clk);
      end
      chk($sformatf("alt_grant%0d", i), g, i % 2);
      @(negedge clk); @(negedge clk);
      chk($sformatf("alt_rsp_valid%0d", i), {rsp1_valid, rsp0_valid}, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("alt_result%0d", i), {rsp_result, rsp_zero}, (i % 2) ? {32'd0, 1'b1} : {32'd6, 1'b0});
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
      @(negedge clk);
      #1;
    end
    rsp0_ready = 0; rsp1_ready = 0;
    rr_m = 0; cnt_m = 4;
    chk("alt_op_count", op_count, cnt_m);

    // Reset pulsed during EXEC: no response for that operation.
    req0_valid = 1; req0_op1 = 11; req0_op2 = 4; req0_ctrl = 4'b0110;
    @(posedge clk); #1; req0_valid = 0;
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    rst_n = 0;
    #1;
    chk_reset_outputs("mid_exec");
    @(negedge clk);
    rst_n = 1;
    rr_m = 0; cnt_m = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_exec_no_rsp", {rsp1_valid, rsp0_valid, busy}, 0);
    end
    txn(1, 0, 32'd20, 32'd22, 4'b0010, 0, 0, 0, 32'd42, 0, 0, 1, 0, "after_rst");

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    txn(1, 0, 32'd5, 32'd6, 4'b1111, 0, 0, 0, 32'd0, 1, 1, 0, 0, "illegal");
    txn(0, 1, 0, 0, 0, 32'd3, 32'd4, 4'b0010, 32'd7, 0, 0, 0, 0, "legal_after");
`endif

    // Randomized traffic against the transaction-level reference.
    for (int n = 0; n < 150; n++) begin
      int r;
      bit v0, v1, w;
      logic [31:0] a0, b0, a1, b1, wa, wb, er;
      logic [3:0]  c0, c1, wc;
      bit ez, ee;
      r  = $urandom_range(1, 3);
      v0 = r[0]; v1 = r[1];
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      c0 = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6) * 0) : 4'($urandom);
      c1 = 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 6))
          0: c0 = 4'b0010; 1: c0 = 4'b0110; 2: c0 = 4'b0000; 3: c0 = 4'b0001;
          4: c0 = 4'b1000; 5: c0 = 4'b0111; default: c0 = 4'b1001;
        endcase
      end
      w  = (v0 && v1) ? rr_m : v1;
      wa = w ? a1 : a0; wb = w ? b1 : b0; wc = w ? c1 : c0;
      if (CHK_EN && !is_legal(wc)) begin
        er = 0; ez = 1; ee = 1;
      end else begin
        er = alu_fn(wa, wb, wc); ez = (er == 0); ee = 0;
      end
      txn(v0, v1, a0, b0, c0, a1, b1, c1, er, ez, ee,
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
